operand_fetch: RTL and testbench

- Pipeline stage between decode and execute.
- Takes one decoded instruction per cycle over a valid/ready handshake and drives the register-file read addresses.
- Resolves operands in priority order: x0, then EX-stage forwarding, then register-file data.
- Tracks in-flight loads in a scoreboard to stall load-use hazards, and holds the result in a one-entry output register toward execute.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/op_scoreboard.sv | 77 +++++++
 rtl/operand_fetch.sv | 167 ++++++++++++++++
 tb/tb_operand_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU pipeline types and constants used by decode,
//               operand fetch and execute.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int CTRL_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CTRL_W-1:0]     ctrl_t;

    // True when a valid producer targets the given register address.
    function automatic logic addr_hit(input logic v, input reg_addr_t a, input reg_addr_t b);
        return v && (a == b);
    endfunction

endpackage
`default_nettype wire

// File: rtl/op_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : op_scoreboard
// Description : Pending-load scoreboard. One bit per architectural register,
//               set when a load is issued, cleared at load writeback or when
//               an un-issued load is squashed. Provides hazard lookup for two
//               sources plus the destination, treating a same-cycle writeback
//               as already resolved (the register file bypasses it).
// Revision    : 1.0 - initial release
// ============================================================================
module op_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic                  sq_en,
    input  logic [REG_ADDR_W-1:0] sq_addr,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_chk,
    output logic                  hazard
);

    logic [NREGS-1:0] w_sb;
    logic [NREGS-1:0] w_pend;
    logic             w_rs1_pend;
    logic             w_rs2_pend;
    logic             w_rd_pend;

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_bit
            if (i == 0) begin : g_zero
                // x0 never has a pending producer.
                assign w_sb[i] = 1'b0;
            end else begin : g_reg
                logic r_bit;
                // Set takes priority over a same-cycle clear of the same register.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_bit <= 1'b0;
                    end else if (addr_hit(set_en, set_addr, REG_ADDR_W'(i))) begin
                        r_bit <= 1'b1;
                    end else if (addr_hit(clr_en, clr_addr, REG_ADDR_W'(i)) ||
                                 addr_hit(sq_en, sq_addr, REG_ADDR_W'(i))) begin
                        r_bit <= 1'b0;
                    end
                end
                assign w_sb[i] = r_bit;
            end
            // A writeback this cycle already satisfies the read through the RF bypass.
            assign w_pend[i] = w_sb[i] && !addr_hit(clr_en, clr_addr, REG_ADDR_W'(i));
        end
    endgenerate

    // Per-source lookup; index 0 is skipped so x0 never stalls.
    always_comb begin
        w_rs1_pend = 1'b0;
        w_rs2_pend = 1'b0;
        w_rd_pend  = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs1 == REG_ADDR_W'(i)) w_rs1_pend = w_pend[i];
            if (rs2 == REG_ADDR_W'(i)) w_rs2_pend = w_pend[i];
            if (rd  == REG_ADDR_W'(i)) w_rd_pend  = w_pend[i];
        end
    end

    assign hazard = w_rs1_pend || w_rs2_pend || (rd_chk && w_rd_pend);

endmodule
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode-to-execute pipeline stage. Accepts one decoded
//               instruction per cycle, resolves operands (x0, EX forward,
//               register file), stalls load-use and load WAW hazards through
//               a pending-load scoreboard and holds the result in a one-entry
//               output register.
// Options     : OPFETCH_STALL_CNT_EN - adds the 32-bit stall_cnt output that
//               counts cycles in which a valid instruction is held off by a
//               hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int XLEN   = cpu_pkg::XLEN,
    parameter int NREGS  = cpu_pkg::NREGS,
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_rd_we,
    input  logic                  in_is_load,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic [REG_ADDR_W-1:0] rf_rd1_addr,
    output logic [REG_ADDR_W-1:0] rf_rd2_addr,
    input  logic [XLEN-1:0]       rf_rd1_data,
    input  logic [XLEN-1:0]       rf_rd2_data,
    input  logic                  ex_fwd_valid,
    input  logic [REG_ADDR_W-1:0] ex_fwd_addr,
    input  logic [XLEN-1:0]       ex_fwd_data,
    input  logic                  wb_ld_valid,
    input  logic [REG_ADDR_W-1:0] wb_ld_addr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_op_a,
    output logic [XLEN-1:0]       out_op_b,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic                  out_is_load,
`ifdef OPFETCH_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic [CTRL_W-1:0]     out_ctrl
);

    logic                  w_hazard;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_transfer;
    logic                  w_sb_set;
    logic                  w_sb_sq;
    logic [XLEN-1:0]       w_op_a;
    logic [XLEN-1:0]       w_op_b;

    logic                  r_valid;
    logic [XLEN-1:0]       r_op_a;
    logic [XLEN-1:0]       r_op_b;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_rd_we;
    logic                  r_is_load;
    logic [CTRL_W-1:0]     r_ctrl;

    assign rf_rd1_addr = in_rs1;
    assign rf_rd2_addr = in_rs2;

    // Issuing a load that writes a real register marks it pending.
    assign w_sb_set = w_accept && in_is_load && in_rd_we && (in_rd != '0);
    // A squashed load never reaches writeback, so its pending bit is released here.
    // rd_we is required as well: a load that never set a bit must not clear
    // one owned by an earlier in-flight load.
    assign w_sb_sq  = flush && r_valid && r_is_load && r_rd_we && (r_rd != '0);

    op_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (reset_n),
        .set_en   (w_sb_set),
        .set_addr (in_rd),
        .clr_en   (wb_ld_valid),
        .clr_addr (wb_ld_addr),
        .sq_en    (w_sb_sq),
        .sq_addr  (r_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .rd_chk   (in_is_load && in_rd_we),
        .hazard   (w_hazard)
    );

    assign w_ready    = !w_hazard && (!r_valid || out_ready) && !flush;
    assign w_accept   = in_valid && w_ready;
    assign w_transfer = r_valid && out_ready;
    assign in_ready   = w_ready;

    // Operand priority: x0, then EX forward, then register-file data.
    always_comb begin
        w_op_a = rf_rd1_data;
        w_op_b = rf_rd2_data;
        if (in_rs1 == '0) begin
            w_op_a = '0;
        end else if (addr_hit(ex_fwd_valid, ex_fwd_addr, in_rs1)) begin
            w_op_a = ex_fwd_data;
        end
        if (in_rs2 == '0) begin
            w_op_b = '0;
        end else if (addr_hit(ex_fwd_valid, ex_fwd_addr, in_rs2)) begin
            w_op_b = ex_fwd_data;
        end
    end

    // One-entry output register: load on accept, drop on transfer or flush, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_rd      <= '0;
            r_rd_we   <= 1'b0;
            r_is_load <= 1'b0;
            r_ctrl    <= '0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_op_a    <= w_op_a;
            r_op_b    <= w_op_b;
            r_rd      <= in_rd;
            r_rd_we   <= in_rd_we;
            r_is_load <= in_is_load;
            r_ctrl    <= in_ctrl;
        end else if (w_transfer || flush) begin
            r_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_op_a    = r_op_a;
    assign out_op_b    = r_op_b;
    assign out_rd      = r_rd;
    assign out_rd_we   = r_rd_we;
    assign out_is_load = r_is_load;
    assign out_ctrl    = r_ctrl;

`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Count cycles where a presented instruction is blocked by a hazard.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (in_valid && w_hazard && !flush) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch: directed scenarios
//               followed by randomized traffic against a behavioural model.
//               Honours OPFETCH_STALL_CNT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_rd_we, in_is_load;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_rd1_addr, rf_rd2_addr;
    logic [31:0] rf_rd1_data, rf_rd2_data;
    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_addr;
    logic [31:0] ex_fwd_data;
    logic        wb_ld_valid;
    logic [4:0]  wb_ld_addr;
    logic        flush;
    logic        out_valid, out_ready, out_rd_we, out_is_load;
    logic [31:0] out_op_a, out_op_b;
    logic [4:0]  out_rd;
    logic [15:0] out_ctrl;
`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_rd        (in_rd),
        .in_rd_we     (in_rd_we),
        .in_is_load   (in_is_load),
        .in_ctrl      (in_ctrl),
        .rf_rd1_addr  (rf_rd1_addr),
        .rf_rd2_addr  (rf_rd2_addr),
        .rf_rd1_data  (rf_rd1_data),
        .rf_rd2_data  (rf_rd2_data),
        .ex_fwd_valid (ex_fwd_valid),
        .ex_fwd_addr  (ex_fwd_addr),
        .ex_fwd_data  (ex_fwd_data),
        .wb_ld_valid  (wb_ld_valid),
        .wb_ld_addr   (wb_ld_addr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_op_a     (out_op_a),
        .out_op_b     (out_op_b),
        .out_rd       (out_rd),
        .out_rd_we    (out_rd_we),
        .out_is_load  (out_is_load),
`ifdef OPFETCH_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .out_ctrl     (out_ctrl)
    );

    // ---------------- reference model state ----------------
    bit          sb [32];      // registers with a load in flight
    bit          m_v;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_rd;
    bit          m_we, m_ld;
    logic [15:0] m_ctrl;
    logic [31:0] m_cnt;

    int tests = 0;
    int fails = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (sb[i]) sb[i] = 1'b0;
        m_v = 0; m_a = '0; m_b = '0; m_rd = '0; m_we = 0; m_ld = 0; m_ctrl = '0;
        m_cnt = '0;
    endfunction

    // A register still waits on a load unless its writeback lands this cycle.
    function automatic bit waiting(input logic [4:0] r);
        return (r != 0) && sb[r] && !(wb_ld_valid && wb_ld_addr == r);
    endfunction

    function automatic bit model_hazard();
        return waiting(in_rs1) || waiting(in_rs2) ||
               (in_is_load && in_rd_we && waiting(in_rd));
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (ex_fwd_valid && ex_fwd_addr == rs) return ex_fwd_data;
        return rf;
    endfunction

    task automatic set_idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_we = 0; in_is_load = 0;
        in_ctrl = '0; rf_rd1_data = '0; rf_rd2_data = '0;
        ex_fwd_valid = 0; ex_fwd_addr = 0; ex_fwd_data = '0;
        wb_ld_valid = 0; wb_ld_addr = 0; flush = 0; out_ready = 1;
    endtask

    task automatic check_outputs();
        check_val("out_valid", out_valid, m_v);
        if (m_v) begin
            check_val("out_op_a", out_op_a, m_a);
            check_val("out_op_b", out_op_b, m_b);
            check_val("out_rd", out_rd, m_rd);
            check_val("out_rd_we", out_rd_we, m_we);
            check_val("out_is_load", out_is_load, m_ld);
            check_val("out_ctrl", out_ctrl, m_ctrl);
        end
`ifdef OPFETCH_STALL_CNT_EN
        check_val("stall_cnt", stall_cnt, m_cnt);
`endif
    endtask

    // Called just after a falling edge with inputs applied: checks the
    // combinational side, advances the model, clocks, checks the registers.
    task automatic cycle();
        bit haz, rdy, acc;
        #1;
        haz = model_hazard();
        rdy = !haz && (!m_v || out_ready) && !flush;
        acc = in_valid && rdy;
        check_val("in_ready", in_ready, rdy);
        check_val("rf_rd1_addr", rf_rd1_addr, in_rs1);
        check_val("rf_rd2_addr", rf_rd2_addr, in_rs2);
        if (in_valid && haz && !flush) m_cnt = m_cnt + 1;
        if (wb_ld_valid && wb_ld_addr != 0) sb[wb_ld_addr] = 1'b0;
        if (flush && m_v && m_ld && m_we && m_rd != 0) sb[m_rd] = 1'b0;
        if (acc && in_is_load && in_rd_we && in_rd != 0) sb[in_rd] = 1'b1;
        if (acc) begin
            m_v = 1; m_a = resolve(in_rs1, rf_rd1_data); m_b = resolve(in_rs2, rf_rd2_data);
            m_rd = in_rd; m_we = in_rd_we; m_ld = in_is_load; m_ctrl = in_ctrl;
        end else if ((m_v && out_ready) || flush) begin
            m_v = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    logic [31:0] held_a;

    initial begin
        model_reset();
        set_idle();
        reset_n = 0;
        @(negedge clk);
        @(negedge clk);
        // Reset state: everything zero.
        check_val("rst_valid", out_valid, 0);
        check_val("rst_op_a", out_op_a, 0);
        check_val("rst_op_b", out_op_b, 0);
        check_val("rst_rd", {out_rd, out_rd_we, out_is_load}, 0);
        check_val("rst_ctrl", out_ctrl, 0);
        reset_n = 1;

        // x0 reads zero even with a forward to x0 and junk RF data.
        set_idle(); in_valid = 1; in_rs1 = 0; rf_rd1_data = 32'hDEAD;
        ex_fwd_valid = 1; ex_fwd_addr = 0; ex_fwd_data = 32'h1234;
        cycle();
        check_val("x0_op_a", out_op_a, 32'h0);

        // EX forward wins over RF data.
        set_idle(); in_valid = 1; in_rs1 = 5; rf_rd1_data = 32'h22;
        ex_fwd_valid = 1; ex_fwd_addr = 5; ex_fwd_data = 32'h11;
        cycle();
        check_val("fwd_op_a", out_op_a, 32'h11);

        // Load-use: load r7, dependent add stalls until writeback.
        set_idle(); in_valid = 1; in_is_load = 1; in_rd_we = 1; in_rd = 7;
        cycle();
        set_idle(); in_valid = 1; in_rs2 = 7; in_rd = 8; in_rd_we = 1; rf_rd2_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("lu_stall", in_ready, 0);
            cycle();
        end
        wb_ld_valid = 1; wb_ld_addr = 7; rf_rd2_data = 32'h55;
        #1 check_val("lu_release", in_ready, 1);
        cycle();
        check_val("lu_op_b", out_op_b, 32'h55);

        // Backpressure: held entry stays put, no accept, then transfer+accept.
        set_idle(); in_valid = 1; in_rs1 = 2; rf_rd1_data = 32'hA5A5; out_ready = 0;
        held_a = out_op_a;
        for (int i = 0; i < 3; i++) begin
            #1 check_val("bp_ready", in_ready, 0);
            cycle();
            check_val("bp_hold", out_op_a, held_a);
        end
        out_ready = 1;
        cycle();
        check_val("bp_new_a", out_op_a, 32'hA5A5);

        // Flush of a held load releases its scoreboard bit.
        set_idle(); cycle();
        set_idle(); in_valid = 1; in_is_load = 1; in_rd_we = 1; in_rd = 9; out_ready = 0;
        cycle();
        set_idle(); flush = 1; out_ready = 0;
        #1 check_val("fl_no_accept", in_ready, 0);
        cycle();
        check_val("fl_valid", out_valid, 0);
        set_idle(); in_valid = 1; in_rs1 = 9;
        #1 check_val("fl_no_stall", in_ready, 1);
        cycle();

        // Async reset in the middle of a stall on x3.
        set_idle(); in_valid = 1; in_is_load = 1; in_rd_we = 1; in_rd = 3;
        cycle();
        set_idle(); in_valid = 1; in_rs1 = 3;
        cycle();
        #2 reset_n = 0;
        #1 check_val("arst_valid", out_valid, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        check_outputs();
        set_idle(); in_valid = 1; in_rs1 = 3;
        #1 check_val("arst_accept", in_ready, 1);
`ifdef OPFETCH_STALL_CNT_EN
        check_val("arst_cnt", stall_cnt, 0);
`endif
        cycle();

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_rs1       = 5'($urandom_range(0, 7));
            in_rs2       = 5'($urandom_range(0, 7));
            in_rd        = 5'($urandom_range(0, 7));
            in_is_load   = ($urandom_range(0, 2) == 0);
            in_rd_we     = in_is_load ? 1'b1 : 1'($urandom_range(0, 1));
            in_ctrl      = 16'($urandom);
            rf_rd1_data  = $urandom;
            rf_rd2_data  = $urandom;
            ex_fwd_valid = 1'($urandom_range(0, 1));
            ex_fwd_addr  = 5'($urandom_range(0, 7));
            ex_fwd_data  = $urandom;
            wb_ld_valid  = ($urandom_range(0, 2) == 0);
            wb_ld_addr   = 5'($urandom_range(0, 7));
            flush        = ($urandom_range(0, 11) == 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
